// File: rtl/seven_segment_pkg.sv
// ============================================================================
// Module   : seven_segment_pkg
// Purpose  : Shared seven-segment constants, legal glyph table, one-hot helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seven_segment_pkg;

  // Segment bit positions within a {g,f,e,d,c,b,a} bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs; the array index is the hex value the glyph shows
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_pattern_decoder.sv
// ============================================================================
// Module   : seven_segment_pattern_decoder
// Purpose  : Active-high 7-bit segment pattern -> hex nibble plus legal flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_TABLE[i]) begin
        nibble_o = 4'(i);
        legal_o  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_reader.sv
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Recovers hex digits from a scanned seven-segment bus after a
//            programmable dwell. Define SEVEN_SEGMENT_READER_SYNC_EN to add
//            two-flop input synchronizers (+2 cycles latency).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int STABLE_COUNT = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                  clock_pos,
  input  logic                  reset_pos,
  input  logic                  common_anod,
  input  logic [6:0]            segment_in,
  input  logic [DIGITS-1:0]     digit_select,
  output logic [4*DIGITS-1:0]   vector_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     pattern_error,
  output logic                  update_pulse
);

  localparam int                     RAW_W    = DIGITS + 7;
  localparam logic [COUNT_WIDTH-1:0] C_STABLE = COUNT_WIDTH'(STABLE_COUNT);
  localparam logic [COUNT_WIDTH-1:0] C_ONE    = COUNT_WIDTH'(1);

  logic [6:0]        seg;
  logic [DIGITS-1:0] sel;
  logic              anod;

`ifdef SEVEN_SEGMENT_READER_SYNC_EN
  logic [6:0]        seg_meta_q,  seg_sync_q;
  logic [DIGITS-1:0] sel_meta_q,  sel_sync_q;
  logic              anod_meta_q, anod_sync_q;

  always_ff @(posedge clock_pos) begin
    if (reset_pos) begin
      seg_meta_q  <= '0;
      seg_sync_q  <= '0;
      sel_meta_q  <= '0;
      sel_sync_q  <= '0;
      anod_meta_q <= 1'b0;
      anod_sync_q <= 1'b0;
    end else begin
      seg_meta_q  <= segment_in;
      seg_sync_q  <= seg_meta_q;
      sel_meta_q  <= digit_select;
      sel_sync_q  <= sel_meta_q;
      anod_meta_q <= common_anod;
      anod_sync_q <= anod_meta_q;
    end
  end

  assign seg  = seg_sync_q;
  assign sel  = sel_sync_q;
  assign anod = anod_sync_q;
`else
  assign seg  = segment_in;
  assign sel  = digit_select;
  assign anod = common_anod;
`endif

  logic [6:0]       pattern;
  logic [RAW_W-1:0] raw;
  logic             sel_onehot;
  logic [3:0]       nibble;
  logic             legal;

  assign pattern    = anod ? ~seg : seg;
  assign raw        = {sel, pattern};
  assign sel_onehot = is_onehot(8'(sel));

  seven_segment_pattern_decoder u_decoder (
    .pattern_i (pattern),
    .nibble_o  (nibble),
    .legal_o   (legal)
  );

  logic [RAW_W-1:0]       sample_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   commit;
  logic [4*DIGITS-1:0]    vector_q;
  logic [DIGITS-1:0]      valid_q;
  logic [DIGITS-1:0]      error_q;
  logic                   pulse_q;

  // Commit only on the edge the count first reaches STABLE_COUNT, so a held
  // input saturates without re-committing.
  always_comb begin
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (raw == sample_q) begin
      cnt_d  = (cnt_q >= C_STABLE) ? C_STABLE : cnt_q + C_ONE;
      commit = (cnt_q < C_STABLE) && (cnt_d == C_STABLE);
    end else begin
      cnt_d  = C_ONE;
      commit = (C_ONE == C_STABLE);
    end
  end

  always_ff @(posedge clock_pos) begin
    if (reset_pos) begin
      sample_q <= {{DIGITS{1'b0}}, SEG_BLANK};
      cnt_q    <= '0;
      vector_q <= '0;
      valid_q  <= '0;
      error_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sample_q <= raw;
      cnt_q    <= cnt_d;
      pulse_q  <= commit;
      for (int i = 0; i < DIGITS; i++) begin
        if (commit && sel[i]) begin
          if (legal) begin
            vector_q[4*i +: 4] <= nibble;
            valid_q[i]         <= 1'b1;
            error_q[i]         <= 1'b0;
          end else begin
            error_q[i]         <= 1'b1;
          end
        end
      end
    end
  end

  assign vector_out    = vector_q;
  assign digit_valid   = valid_q;
  assign pattern_error = error_q;
  assign update_pulse  = pulse_q;

endmodule

`default_nettype wire
